// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu : multi-cycle ALU with a valid/ready request and result handshake.
//
// Most operations finish one cycle after they are accepted. MUL uses a
// shift-add loop and DIV uses restoring division. Each loop produces one bit
// per cycle for WIDTH cycles.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : request offered
//   in_ready   : block idle and able to accept a request
//   opcode     : 0 ADD 1 SUB 2 MUL 3 DIV 4 SHL 5 SHR 6 ROL 7 ROR
//                8 AND 9 OR A XOR B NOR C NAND D XNOR E GT F EQ
//   operand1/2 : unsigned operands (operand2[SHW-1:0] = shift/rotate amount)
//   out_valid  : result/flags valid, held until out_ready
//   out_ready  : consumer accepts the result
//   result     : operation result (low WIDTH bits for ADD/SUB/MUL)
//   flag_zero  : result == 0
//   flag_ovf   : ADD carry, SUB borrow, MUL product overflow
//   flag_dz    : DIV by zero (result forced to all ones)
// ---------------------------------------------------------------------------
module iter_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_ovf,
  output logic             flag_dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;

  // Rotation is built as a log-shifter of fixed rotates. The total amount is
  // therefore taken modulo WIDTH, which also covers WIDTH that is not a power of two.
  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0]   s);
    logic [WIDTH-1:0] r;
    r = v;
    for (int k = 0; k < SHW; k++) begin
      if (s[k]) r = (r << ((1 << k) % WIDTH)) | (r >> (WIDTH - ((1 << k) % WIDTH)));
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v,
                                                 input logic [SHW-1:0]   s);
    logic [WIDTH-1:0] r;
    r = v;
    for (int k = 0; k < SHW; k++) begin
      if (s[k]) r = (r >> ((1 << k) % WIDTH)) | (r << (WIDTH - ((1 << k) % WIDTH)));
    end
    return r;
  endfunction

  // Single-cycle results, computed straight from the request inputs
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_dz;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [SHW-1:0]   amt;

  always_comb begin
    add_ext = {1'b0, operand1} + {1'b0, operand2};
    sub_ext = {1'b0, operand1} - {1'b0, operand2};
    amt     = operand2[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_res = add_ext[WIDTH-1:0]; alu_ovf = add_ext[WIDTH]; end
      OP_SUB:  begin alu_res = sub_ext[WIDTH-1:0]; alu_ovf = sub_ext[WIDTH]; end
      OP_MUL:  alu_res = '0;
      OP_DIV:  begin alu_res = '1; alu_dz = 1'b1; end  // only used when operand2 == 0
      OP_SHL:  alu_res = operand1 << amt;
      OP_SHR:  alu_res = operand1 >> amt;
      OP_ROL:  alu_res = rot_left(operand1, amt);
      OP_ROR:  alu_res = rot_right(operand1, amt);
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_NAND: alu_res = ~(operand1 & operand2);
      OP_XNOR: alu_res = ~(operand1 ^ operand2);
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, operand1 > operand2};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, operand1 == operand2};
      default: alu_res = '0;
    endcase
  end

  // One iteration of the shift-add multiplier or the restoring divider
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_ge    = div_trial >= {1'b0, b_q};
    if (op_q == OP_MUL) begin
      step_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_ge) begin
      step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // reset_n gates in_ready so the block never looks ready while held in reset
  assign in_ready  = (state == S_IDLE) && reset_n;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      flag_zero <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_dz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= opcode;
            a_q  <= operand1;
            b_q  <= operand2;
            if (opcode == OP_MUL) begin
              acc   <= {{WIDTH{1'b0}}, operand2};
              cnt   <= CW'(WIDTH);
              state <= S_BUSY;
            end else if (opcode == OP_DIV && operand2 != '0) begin
              acc   <= {{WIDTH{1'b0}}, operand1};
              cnt   <= CW'(WIDTH);
              state <= S_BUSY;
            end else begin
              result    <= alu_res;
              flag_zero <= (alu_res == '0);
              flag_ovf  <= alu_ovf;
              flag_dz   <= alu_dz;
              state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= step_next[WIDTH-1:0];
            flag_zero <= (step_next[WIDTH-1:0] == '0);
            flag_ovf  <= (op_q == OP_MUL) && (step_next[2*WIDTH-1:WIDTH] != '0);
            flag_dz   <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag_zero, flag_ovf, flag_dz;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         d;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic o,
                                output logic d, output int lat);
    longint unsigned x, y, m, full;
    int s;
    x = 64'(a); y = 64'(b); m = (64'd1 << W) - 1; s = int'(b) % W;
    full = 0; o = 1'b0; d = 1'b0; lat = 1;
    case (op)
      4'h0: begin full = x + y; o = full > m; end
      4'h1: begin full = (x - y) & m; o = y > x; end
      4'h2: begin full = x * y; o = full > m; lat = W + 1; end
      4'h3: if (y == 0) begin full = m; d = 1'b1; end
            else begin full = x / y; lat = W + 1; end
      4'h4: full = x << s;
      4'h5: full = x >> s;
      4'h6: full = (x << s) | (x >> (W - s));
      4'h7: full = (x >> s) | (x << (W - s));
      4'h8: full = x & y;
      4'h9: full = x | y;
      4'hA: full = x ^ y;
      4'hB: full = ~(x | y);
      4'hC: full = ~(x & y);
      4'hD: full = ~(x ^ y);
      4'hE: full = (x > y) ? 1 : 0;
      default: full = (x == y) ? 1 : 0;
    endcase
    r = W'(full & m);
    z = (r == '0);
  endfunction

  // Issue one request and wait for its result. Inputs are scrambled after
  // acceptance to show they are ignored. out_ready is held low for `stall`
  // cycles of DONE before the result is consumed.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall,
                        output logic [W-1:0] r, output logic z, output logic o,
                        output logic d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; opcode = 4'($urandom); operand1 = W'($urandom); operand2 = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
    r = result; z = flag_zero; o = flag_ovf; d = flag_dz;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_res"}, 64'(result), 64'(r));
      chk({tag, "_hold_flags"}, 64'({flag_zero, flag_ovf, flag_dz}), 64'({z, o, d}));
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    chk({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_consumed_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_consumed_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t         vt[18];
    logic [W-1:0] r, er;
    logic         z, o, d, ez, eo, ed;
    int           lat, elat;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    vt[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vt[1]  = '{4'h2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17};
    vt[2]  = '{4'h2, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 1'b0, 17};
    vt[3]  = '{4'h3, 16'd100,  16'd7,    16'h000E, 1'b0, 1'b0, 1'b0, 17};
    vt[4]  = '{4'h3, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1};
    vt[5]  = '{4'h6, 16'h1234, 16'h0004, 16'h2341, 1'b0, 1'b0, 1'b0, 1};
    vt[6]  = '{4'h5, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vt[7]  = '{4'h7, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1};
    vt[8]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1};
    vt[9]  = '{4'hE, 16'h0005, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vt[10] = '{4'hF, 16'h0007, 16'h0007, 16'h0001, 1'b0, 1'b0, 1'b0, 1};
    vt[11] = '{4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vt[12] = '{4'hD, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b0, 1'b0, 1'b0, 1};
    vt[13] = '{4'hB, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1};
    vt[14] = '{4'h4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1};
    vt[15] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 17};
    vt[16] = '{4'h3, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17};
    vt[17] = '{4'h3, 16'h0007, 16'd100,  16'h0000, 1'b1, 1'b0, 1'b0, 17};

    // Reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_zero, flag_ovf, flag_dz}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 0, r, z, o, d, lat);
      chk($sformatf("vec%0d_res", i), 64'(r), 64'(vt[i].res));
      chk($sformatf("vec%0d_flags", i), 64'({z, o, d}), 64'({vt[i].z, vt[i].o, vt[i].d}));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
    end

    // Backpressure: SUB held for 5 cycles without out_ready
    run_op("bp_sub", 4'h1, 16'h0003, 16'h0005, 5, r, z, o, d, lat);
    chk("bp_sub_res", 64'(r), 64'hFFFE);
    chk("bp_sub_ovf", 64'(o), 64'd1);

    // Reset in the middle of a MUL
    run_op("pre_add", 4'h0, 16'h0001, 16'h0001, 0, r, z, o, d, lat);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h2; operand1 = 16'h0100; operand2 = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_flags", 64'({flag_zero, flag_ovf, flag_dz}), 64'd0);
    @(negedge clk);
    chk("midrst_hold_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    run_op("after_rst_add", 4'h0, 16'd2, 16'd3, 0, r, z, o, d, lat);
    chk("after_rst_res", 64'(r), 64'h0005);
    chk("after_rst_lat", 64'(lat), 64'd1);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      model(op, a, b, er, ez, eo, ed, elat);
      run_op($sformatf("rnd%0d", i), op, a, b, int'($urandom_range(0, 2)), r, z, o, d, lat);
      chk($sformatf("rnd%0d_op%0h_%0h_%0h_res", i, op, a, b), 64'(r), 64'(er));
      chk($sformatf("rnd%0d_flags", i), 64'({z, o, d}), 64'({ez, eo, ed}));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
